// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: op codes, FSM
// states and the per-op alignment / byte-lane helpers.
package mem_lsu_pkg;

  typedef enum logic [2:0] {
    LSU_LW  = 3'd0,
    LSU_LH  = 3'd1,
    LSU_LHU = 3'd2,
    LSU_LB  = 3'd3,
    LSU_LBU = 3'd4,
    LSU_SW  = 3'd5,
    LSU_SH  = 3'd6,
    LSU_SB  = 3'd7
  } lsu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEM,
    ST_RESP
  } lsu_state_e;

  function automatic logic is_store(lsu_op_e op);
    return (op == LSU_SW) || (op == LSU_SH) || (op == LSU_SB);
  endfunction

  // Word ops need lane 0, half ops an even lane, byte ops any lane.
  function automatic logic is_aligned(lsu_op_e op, logic [1:0] lane);
    case (op)
      LSU_LW, LSU_SW:          return lane == 2'b00;
      LSU_LH, LSU_LHU, LSU_SH: return !lane[0];
      LSU_LB, LSU_LBU, LSU_SB: return 1'b1;
      default:                 return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(lsu_op_e op, logic [1:0] lane);
    case (op)
      LSU_LB, LSU_LBU, LSU_SB: return 4'b0001 << lane;
      LSU_LH, LSU_LHU, LSU_SH: return 4'b0011 << {lane[1], 1'b0};
      LSU_LW, LSU_SW:          return 4'b1111;
      default:                 return 4'b0000;
    endcase
  endfunction

  // Replicate the narrow store value across every lane so the memory only
  // has to honour the byte enables.
  function automatic logic [31:0] store_data(lsu_op_e op, logic [31:0] wdata);
    case (op)
      LSU_SB:  return {4{wdata[7:0]}};
      LSU_SH:  return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half of a returned memory word and sign- or
// zero-extends it to 32 bits; word loads pass through, stores yield zero.
module load_extend
  import mem_lsu_pkg::*;
(
  input  lsu_op_e     op,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  output logic [31:0] ext
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection followed by extension according to the load type.
  always_comb begin
    w_byte = word[7:0];
    case (lane)
      2'd0: w_byte = word[7:0];
      2'd1: w_byte = word[15:8];
      2'd2: w_byte = word[23:16];
      2'd3: w_byte = word[31:24];
      default: w_byte = word[7:0];
    endcase
    w_half = lane[1] ? word[31:16] : word[15:0];
    ext    = '0;
    case (op)
      LSU_LB:  ext = {{24{w_byte[7]}}, w_byte};
      LSU_LBU: ext = {24'd0, w_byte};
      LSU_LH:  ext = {{16{w_half[15]}}, w_half};
      LSU_LHU: ext = {16'd0, w_half};
      LSU_LW:  ext = word;
      default: ext = '0;
    endcase
  end

endmodule

// File: rtl/mem_load_store_unit.sv
// Multi-cycle data-memory access unit: accepts one CPU load/store at a time,
// checks alignment, runs a req/ack transaction with the data memory and
// returns the extended load data (or an error) as a one-cycle response.
module mem_load_store_unit
  import mem_lsu_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 0
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  r_state;
  lsu_op_e     r_op;
  logic [1:0]  r_lane;
  logic [31:0] r_cnt;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [3:0]  r_mem_be;
  logic [31:0] r_mem_wdata;

  lsu_op_e     w_op;
  logic        w_aligned;
  logic        w_timeout;
  logic [31:0] w_ext;

  assign w_op      = lsu_op_e'(op);
  assign w_aligned = is_aligned(w_op, addr[1:0]);
  // r_cnt counts completed MEM cycles without an ack; the last allowed one
  // is cycle ACK_TIMEOUT, i.e. when the count still reads ACK_TIMEOUT-1.
  assign w_timeout = (ACK_TIMEOUT != 0) && (r_cnt == ACK_TIMEOUT - 1);

  load_extend u_load_extend (
    .op   (r_op),
    .lane (r_lane),
    .word (mem_rdata),
    .ext  (w_ext)
  );

  // Access FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_op         <= LSU_LW;
      r_lane       <= '0;
      r_cnt        <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_be     <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_op        <= w_op;
            r_lane      <= addr[1:0];
            r_req_ready <= 1'b0;
            if (w_aligned) begin
              r_state     <= ST_MEM;
              r_cnt       <= '0;
              r_mem_req   <= 1'b1;
              r_mem_we    <= is_store(w_op);
              r_mem_addr  <= {addr[31:2], 2'b00};
              r_mem_be    <= byte_enables(w_op, addr[1:0]);
              r_mem_wdata <= store_data(w_op, wdata);
            end else begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_err        <= 1'b1;
              r_rdata      <= '0;
            end
          end
        end
        ST_MEM: begin
          if (mem_ack) begin
            r_state      <= ST_RESP;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_err        <= 1'b0;
            r_rdata      <= is_store(r_op) ? '0 : w_ext;
          end else if (w_timeout) begin
            r_state      <= ST_RESP;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_err        <= 1'b1;
            r_rdata      <= '0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        ST_RESP: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
          r_mem_req   <= 1'b0;
          r_mem_we    <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign rdata      = r_rdata;
  assign err        = r_err;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_be     = r_mem_be;
  assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_mem_load_store_unit.sv
// Bench for mem_load_store_unit: directed transactions with literal expected
// values, plus a per-cycle compare against a timeline/data model.
module tb_mem_load_store_unit;

  localparam logic [2:0] OP_LW = 3'd0, OP_LH = 3'd1, OP_LHU = 3'd2, OP_LB = 3'd3,
                         OP_LBU = 3'd4, OP_SW = 3'd5, OP_SH = 3'd6, OP_SB = 3'd7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  op = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  mem_load_store_unit #(.ACK_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .op(op), .addr(addr), .wdata(wdata), .resp_valid(resp_valid),
    .rdata(rdata), .err(err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic chkb(input string nm, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // ---- behavioural model: plain arithmetic on the access rules ----
  function automatic bit m_is_store(logic [2:0] o);
    return o == OP_SW || o == OP_SH || o == OP_SB;
  endfunction

  function automatic int unsigned m_size(logic [2:0] o);
    if (o == OP_LW || o == OP_SW) return 4;
    if (o == OP_LH || o == OP_LHU || o == OP_SH) return 2;
    return 1;
  endfunction

  function automatic bit m_aligned(logic [2:0] o, logic [31:0] a);
    return (a % m_size(o)) == 0;
  endfunction

  function automatic logic [3:0] m_be(logic [2:0] o, logic [31:0] a);
    int unsigned mask;
    mask = (1 << m_size(o)) - 1;
    return 4'(mask << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(logic [2:0] o, logic [31:0] w);
    if (o == OP_SB) return (w % 256) * 32'h01010101;
    if (o == OP_SH) return (w % 65536) * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] m_rdata(logic [2:0] o, logic [31:0] a, logic [31:0] rd);
    logic [31:0] sh, b, h;
    sh = rd >> (8 * (a % 4));
    b  = sh % 256;
    h  = sh % 65536;
    case (o)
      OP_LB:   return (b >= 128) ? b - 256 : b;
      OP_LBU:  return b;
      OP_LH:   return (h >= 32768) ? h - 65536 : h;
      OP_LHU:  return h;
      OP_LW:   return rd;
      default: return 32'd0;
    endcase
  endfunction

  // ---- expected timeline of the current transaction ----
  bit          en = 1'b0;
  bit          e_active = 1'b0;
  int          e_acc = 0, e_nmem = 0, e_resp = 0;
  bit          e_aligned = 1'b0, e_err = 1'b0, e_we = 1'b0;
  logic [31:0] e_addr = '0, e_wdata = '0, e_rdata = '0;
  logic [3:0]  e_be = '0;
  logic [31:0] l_rdata = '0;
  logic        l_err = 1'b0;

  // Per-cycle compare of every output against the model timeline.
  always @(negedge clk) begin
    bit in_busy, in_mem, at_resp;
    if (en) begin
      in_busy = e_active && cyc >= e_acc && cyc <= e_resp;
      in_mem  = e_active && e_aligned && cyc >= e_acc && cyc < e_acc + e_nmem;
      at_resp = e_active && cyc == e_resp;
      chkb("req_ready", req_ready, !in_busy);
      chkb("mem_req", mem_req, in_mem);
      chkb("resp_valid", resp_valid, at_resp);
      if (in_mem) begin
        chk("mem_addr", mem_addr, e_addr);
        chkb("mem_we", mem_we, e_we);
        chk("mem_be", 32'(mem_be), 32'(e_be));
        chk("mem_wdata", mem_wdata, e_wdata);
      end
      if (at_resp) begin
        chk("rdata", rdata, e_rdata);
        chkb("err", err, e_err);
        l_rdata = e_rdata;
        l_err   = e_err;
      end else begin
        chk("rdata_hold", rdata, l_rdata);
        chkb("err_hold", err, l_err);
      end
    end
  end

  // One CPU access; d = ack delay in MEM cycles, noack lets it time out.
  task automatic run(input string nm, input logic [2:0] o, input logic [31:0] a,
                     input logic [31:0] w, input logic [31:0] rd, input int d,
                     input bit noack, input logic [31:0] lit_rdata, input bit lit_err,
                     input logic [3:0] lit_be, input logic [31:0] lit_wdata);
    logic [31:0] got_rd, got_wd;
    logic [3:0]  got_be;
    logic        got_err;
    bit          seen;
    int          wd;
    got_rd = '0; got_wd = '0; got_be = '0; got_err = 1'b0; seen = 1'b0; wd = 0;
    op = o; addr = a; wdata = w; req_valid = 1'b1; mem_rdata = ~rd;
    @(posedge clk); #1;
    req_valid = 1'b0; addr = ~a; wdata = ~w;
    e_aligned = m_aligned(o, a);
    e_nmem    = e_aligned ? (noack ? 4 : d + 1) : 0;
    e_acc     = cyc;
    e_resp    = e_acc + e_nmem;
    e_addr    = a - (a % 4);
    e_we      = m_is_store(o);
    e_be      = m_be(o, a);
    e_wdata   = m_wdata(o, w);
    e_err     = !e_aligned || noack;
    e_rdata   = e_err ? 32'd0 : m_rdata(o, a, rd);
    e_active  = 1'b1;
    got_be = mem_be;
    got_wd = mem_wdata;
    while (wd < 20) begin
      if (resp_valid) begin
        got_rd = rdata; got_err = err; seen = 1'b1;
      end
      if (cyc > e_resp) break;
      mem_ack   = e_aligned && !noack && (cyc == e_acc + d);
      mem_rdata = mem_ack ? rd : ~rd;
      @(posedge clk); #1;
      wd++;
    end
    mem_ack = 1'b0;
    chkb({nm, "_resp_seen"}, seen, 1'b1);
    chk({nm, "_rdata"}, got_rd, lit_rdata);
    chkb({nm, "_err"}, got_err, lit_err);
    if (e_aligned) chk({nm, "_be"}, 32'(got_be), 32'(lit_be));
    if (e_aligned && e_we) chk({nm, "_wdata"}, got_wd, lit_wdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chkb("rst_req_ready", req_ready, 1'b1);
    chkb("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chkb("rst_err", err, 1'b0);
    chkb("rst_mem_req", mem_req, 1'b0);
    chkb("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_be", 32'(mem_be), 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    en = 1'b1;

    //  name    op      addr          wdata         mem_rdata     d  noack rdata         err  be       wdata
    run("lw",   OP_LW,  32'h00001004, 32'h0,        32'hDEADBEEF, 2, 0, 32'hDEADBEEF, 0, 4'b1111, 32'h0);
    run("lb3",  OP_LB,  32'h00001003, 32'h0,        32'h80FF7F01, 0, 0, 32'hFFFFFF80, 0, 4'b1000, 32'h0);
    run("lbu3", OP_LBU, 32'h00001003, 32'h0,        32'h80FF7F01, 1, 0, 32'h00000080, 0, 4'b1000, 32'h0);
    run("lb1",  OP_LB,  32'h00001001, 32'h0,        32'h80FF7F01, 0, 0, 32'h0000007F, 0, 4'b0010, 32'h0);
    run("lh2",  OP_LH,  32'h00001002, 32'h0,        32'h8001ABCD, 1, 0, 32'hFFFF8001, 0, 4'b1100, 32'h0);
    run("lhu0", OP_LHU, 32'h00001000, 32'h0,        32'h8001ABCD, 0, 0, 32'h0000ABCD, 0, 4'b0011, 32'h0);
    run("sb",   OP_SB,  32'h00002002, 32'h123456AB, 32'h11111111, 0, 0, 32'h0,        0, 4'b0100, 32'hABABABAB);
    run("sh",   OP_SH,  32'h00002002, 32'h123456AB, 32'h22222222, 1, 0, 32'h0,        0, 4'b1100, 32'h56AB56AB);
    run("sw",   OP_SW,  32'h00002004, 32'hCAFEF00D, 32'h33333333, 2, 0, 32'h0,        0, 4'b1111, 32'hCAFEF00D);
    run("lw_mis", OP_LW, 32'h00003002, 32'h0,       32'h44444444, 0, 0, 32'h0,        1, 4'b0000, 32'h0);
    run("sh_mis", OP_SH, 32'h00003001, 32'h5555,    32'h55555555, 0, 0, 32'h0,        1, 4'b0000, 32'h0);
    run("lw_to", OP_LW,  32'h00005000, 32'h0,       32'h66666666, 0, 1, 32'h0,        1, 4'b1111, 32'h0);
    run("lb_ok", OP_LB,  32'h00005002, 32'h0,       32'h00C30000, 2, 0, 32'hFFFFFFC3, 0, 4'b0100, 32'h0);

    // Stray ack while idle must not start or finish anything.
    mem_ack = 1'b1; mem_rdata = 32'h77777777;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a memory access, then a late ack.
    en = 1'b0;
    op = OP_LW; addr = 32'h00004000; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chkb("rst_mid_mem_req_on", mem_req, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chkb("rst_mid_mem_req", mem_req, 1'b0);
    chkb("rst_mid_req_ready", req_ready, 1'b1);
    chkb("rst_mid_resp_valid", resp_valid, 1'b0);
    mem_ack = 1'b1; mem_rdata = 32'h00000055;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chkb("late_ack_resp_valid", resp_valid, 1'b0);
    chkb("late_ack_mem_req", mem_req, 1'b0);
    chk("late_ack_rdata", rdata, 32'h0);
    chkb("late_ack_err", err, 1'b0);
    @(posedge clk); #1;
    chkb("late_ack_resp_valid2", resp_valid, 1'b0);
    chkb("late_ack_req_ready", req_ready, 1'b1);
    e_active = 1'b0; l_rdata = '0; l_err = 1'b0;
    en = 1'b1;

    run("lw_after_rst", OP_LW, 32'h00006008, 32'h0, 32'h0BADF00D, 0, 0, 32'h0BADF00D, 0, 4'b1111, 32'h0);

    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_load_store_unit.md
Name: mem_load_store_unit

Overview:
- Multi-cycle data-memory access unit for the MIPS datapath; it is the data-side counterpart of the immediate extender.
- Stores: narrows and replicates register data into byte lanes and generates byte enables.
- Loads: reads the returned memory word back and sign- or zero-extends the selected byte or half to 32 bits.
- Sits between the execute stage and a data memory that answers with a req/ack handshake of variable latency.

Parameters:
ACK_TIMEOUT, 0, cycles to wait for mem_ack before aborting with err; 0 disables the timeout.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high; clears all state
req_valid  input  1  CPU-side access request
req_ready  output  1  unit can accept a request (high only in IDLE)
op  input  3  access type; LSU_* encoding in package
addr  input  32  byte address
wdata  input  32  store data (low byte/half used for SB/SH)
resp_valid  output  1  one-cycle pulse: access finished
rdata  output  32  extended load data, valid with resp_valid
err  output  1  misaligned or timed out, valid with resp_valid
mem_req  output  1  memory request, held until mem_ack
mem_we  output  1  write strobe
mem_addr  output  32  word address, i.e. addr with bits [1:0] forced to 0
mem_be  output  4  byte enables
mem_wdata  output  32  lane-replicated store data
mem_ack  input  1  memory completion, sampled while mem_req=1
mem_rdata  input  32  read word, valid when mem_ack=1

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, rdata=0, err=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, timeout counter=0.
- States are IDLE, MEM and RESP.
- IDLE: req_ready=1. On req_valid, latch op and addr[1:0], and run the alignment check.
  - Alignment rule: LW/SW need addr[1:0]=00; LH/LHU/SH need addr[0]=0; byte accesses are always aligned.
  - Misaligned: go to RESP with err=1 and rdata=0. mem_req is never raised.
  - Aligned: go to MEM and register mem_addr, mem_we, mem_be and mem_wdata.
- Byte enables:
  - SB/LB/LBU: 0001 shifted left by addr[1:0].
  - SH/LH/LHU: 0011 shifted by addr[1]*2.
  - SW/LW: 1111.
  - mem_be is also driven on loads.
- Store data replication: SB drives {4{wdata[7:0]}}; SH drives {2{wdata[15:0]}}; SW drives wdata.
- MEM: mem_req=1 with all mem_* outputs held stable.
  - On mem_ack=1, capture the extended mem_rdata into rdata (stores return 0) and go to RESP.
  - If ACK_TIMEOUT>0 and the counter reaches ACK_TIMEOUT with no ack, go to RESP with err=1 and rdata=0.
  - The counter clears on entry to MEM.
- Load extension:
  - LB: sign-extend the byte at lane addr[1:0]. LBU: zero-extend it.
  - LH: sign-extend half [15:0] or [31:16], selected by addr[1]. LHU: zero-extend it.
  - LW: word passed through.
- RESP: resp_valid=1 for exactly one cycle, then go to IDLE. rdata and err hold their values until the next resp_valid.
- mem_req drops in the cycle after the ack.
- Minimum latency: accept at edge N, mem_req high in cycle N+1, ack in the same cycle, resp_valid in cycle N+2. The next request can be accepted at edge N+3.
- Requests presented outside IDLE are ignored (req_ready=0). A mem_ack while mem_req=0 is ignored.
- Undefined op codes are treated as misaligned: err=1 and no memory access.
- Reset mid-access drops mem_req in the next cycle. Any outstanding ack is discarded.

Decomposition:
- Package mem_lsu_pkg holds:
  - op encodings: LSU_LW=0, LSU_LH=1, LSU_LHU=2, LSU_LB=3, LSU_LBU=4, LSU_SW=5, LSU_SH=6, LSU_SB=7;
  - state encodings ST_IDLE, ST_MEM, ST_RESP;
  - an is_store helper.
- One natural combinational sub-module, load_extend, with inputs op, lane (2 bits) and word, and output ext (32 bits).

Test Plan:
- Aligned LW: op=LW, addr=0x1004, ack after 2 cycles with mem_rdata=0xDEADBEEF -> mem_addr=0x1004, mem_be=1111, rdata=0xDEADBEEF, err=0, resp_valid 4 cycles after accept.
- Byte loads: mem_rdata=0x80FF7F01 -> LB@addr 0x..03 returns 0xFFFFFF80; LBU@0x..03 returns 0x00000080; LB@0x..01 returns 0x0000007F.
- Half loads: mem_rdata=0x8001ABCD -> LH@0x..02 returns 0xFFFF8001; LHU@0x..00 returns 0x0000ABCD.
- Stores: SB addr=0x2002 wdata=0x123456AB -> mem_be=0100, mem_wdata=0xABABABAB, mem_we=1; SH addr=0x2002 -> mem_be=1100, mem_wdata=0x56AB56AB.
- Misaligned: LW at addr=0x3002 and SH at addr=0x3001 -> mem_req never asserted, resp_valid 1 cycle after accept, err=1, rdata=0.
- Timeout and reset: with ACK_TIMEOUT=4 and no ack -> err=1 resp after 4 MEM cycles. Reset asserted during MEM -> mem_req=0 next cycle, req_ready=1, and a late ack is ignored.
